// File: rtl/ftsd_scan_ctrl_pkg.sv
// Shared segment encodings (active-low, 14 segments plus decimal point) and sizing helper.
// Bit order, MSB first: a b c d e f g1 g2 h i j k l m dp.
package ftsd_scan_ctrl_pkg;

  localparam logic [14:0] FTSD_ZERO    = 15'h01FF;
  localparam logic [14:0] FTSD_ONE     = 15'h4FFF;
  localparam logic [14:0] FTSD_TWO     = 15'h127F;
  localparam logic [14:0] FTSD_THREE   = 15'h067F;
  localparam logic [14:0] FTSD_FOUR    = 15'h4C7F;
  localparam logic [14:0] FTSD_FIVE    = 15'h247F;
  localparam logic [14:0] FTSD_SIX     = 15'h207F;
  localparam logic [14:0] FTSD_SEVEN   = 15'h0FFF;
  localparam logic [14:0] FTSD_EIGHT   = 15'h007F;
  localparam logic [14:0] FTSD_NINE    = 15'h047F;
  localparam logic [14:0] FTSD_A       = 15'h087F;
  localparam logic [14:0] FTSD_B       = 15'h075B;
  localparam logic [14:0] FTSD_C       = 15'h31FF;
  localparam logic [14:0] FTSD_D       = 15'h07DB;
  localparam logic [14:0] FTSD_E       = 15'h30FF;
  localparam logic [14:0] FTSD_F       = 15'h38FF;
  localparam logic [14:0] FTSD_BLANK   = 15'h7FFF;
  localparam logic [14:0] FTSD_DEFAULT = 15'h7FFF;

  // Counter/index width that stays at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ftsd_scan_ctrl_decoder.sv
// Hex nibble to fourteen-segment pattern, purely combinational.
module ftsd_scan_ctrl_decoder
  import ftsd_scan_ctrl_pkg::*;
(
  input  logic [3:0]  i_hex,
  output logic [14:0] o_seg
);

  always_comb begin
    o_seg = FTSD_DEFAULT;
    case (i_hex)
      4'h0: o_seg = FTSD_ZERO;
      4'h1: o_seg = FTSD_ONE;
      4'h2: o_seg = FTSD_TWO;
      4'h3: o_seg = FTSD_THREE;
      4'h4: o_seg = FTSD_FOUR;
      4'h5: o_seg = FTSD_FIVE;
      4'h6: o_seg = FTSD_SIX;
      4'h7: o_seg = FTSD_SEVEN;
      4'h8: o_seg = FTSD_EIGHT;
      4'h9: o_seg = FTSD_NINE;
      4'hA: o_seg = FTSD_A;
      4'hB: o_seg = FTSD_B;
      4'hC: o_seg = FTSD_C;
      4'hD: o_seg = FTSD_D;
      4'hE: o_seg = FTSD_E;
      4'hF: o_seg = FTSD_F;
      default: o_seg = FTSD_DEFAULT;
    endcase
  end

endmodule

// File: rtl/ftsd_scan_ctrl.sv
// Time-multiplexed FTSD scanner: one active-low digit enable per slot after a dark dead-time,
// with per-digit blank/blink and leading-zero suppression. Outputs lag counters by one cycle.
module ftsd_scan_ctrl
  import ftsd_scan_ctrl_pkg::*;
#(
  parameter  int DIGITS    = 4,
  parameter  int SCAN_DIV  = 50000,
  parameter  int DEAD      = 500,
  parameter  int BLINK_DIV = 12500000,
  localparam int IDX_W     = clog2_min1(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lzs,
  output logic [14:0]           ftsd,
  output logic [DIGITS-1:0]     ftsd_ctl,
  output logic [IDX_W-1:0]      scan_idx
);

  localparam int SLOT_W  = clog2_min1(SCAN_DIV);
  localparam int BLINK_W = clog2_min1(BLINK_DIV);

  logic [SLOT_W-1:0]  r_slot;
  logic [IDX_W-1:0]   r_idx;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_blink_phase;
  logic [14:0]        r_ftsd;
  logic [DIGITS-1:0]  r_ctl;

  logic               w_slot_wrap;
  logic               w_blink_wrap;
  logic               w_dead;
  logic [3:0]         w_nib;
  logic [14:0]        w_dec;
  logic [DIGITS-1:0]  w_upper_zero;
  logic               w_sel_blank;
  logic               w_sel_blink;
  logic               w_sel_lz;
  logic               w_off;

  assign w_slot_wrap  = (r_slot == SLOT_W'(SCAN_DIV - 1));
  assign w_blink_wrap = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));
  assign w_dead       = (int'(r_slot) < DEAD);

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      r_slot        <= '0;
      r_idx         <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_slot <= w_slot_wrap ? '0 : r_slot + SLOT_W'(1);
      if (w_slot_wrap)
        r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BLINK_W'(1);
      if (w_blink_wrap)
        r_blink_phase <= ~r_blink_phase;
    end
  end

  // w_upper_zero[i]: digit i and every more-significant digit are zero.
  always_comb begin
    logic acc;
    acc          = 1'b1;
    w_upper_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc             = acc & (digits[4*i +: 4] == 4'h0);
      w_upper_zero[i] = acc;
    end
  end

  always_comb begin
    w_nib       = 4'h0;
    w_sel_blank = 1'b0;
    w_sel_blink = 1'b0;
    w_sel_lz    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = digits[4*i +: 4];
        w_sel_blank = blank[i];
        w_sel_blink = blink[i];
        w_sel_lz    = w_upper_zero[i];
      end
    end
  end

  ftsd_scan_ctrl_decoder u_dec (
    .i_hex (w_nib),
    .o_seg (w_dec)
  );

  assign w_off = w_sel_blank
               | (w_sel_blink & r_blink_phase)
               | (lzs & (r_idx != '0) & w_sel_lz);

  // Dead-time forces all enables high, so a slot change never overlaps two digits.
  always_ff @(posedge clk) begin
    if (!rst_n || !en || w_dead) begin
      r_ftsd <= FTSD_BLANK;
      r_ctl  <= '1;
    end else begin
      r_ftsd <= w_off ? FTSD_BLANK : w_dec;
      r_ctl  <= ~(DIGITS'(1) << r_idx);
    end
  end

  assign ftsd     = r_ftsd;
  assign ftsd_ctl = r_ctl;
  assign scan_idx = r_idx;

endmodule

// File: tb/tb_ftsd_scan_ctrl.sv
// Scoreboard bench: stimulus pushes the hand-derived expected output per cycle, a monitor pops and compares.
module tb_ftsd_scan_ctrl;
  import ftsd_scan_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, en, lzs;
  logic [15:0] digits;
  logic [3:0]  blank, blink;
  logic [14:0] ftsd;
  logic [3:0]  ftsd_ctl;
  logic [1:0]  scan_idx;

  always #5 clk = ~clk;

  ftsd_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .DEAD(1), .BLINK_DIV(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .digits   (digits),
    .blank    (blank),
    .blink    (blink),
    .lzs      (lzs),
    .ftsd     (ftsd),
    .ftsd_ctl (ftsd_ctl),
    .scan_idx (scan_idx)
  );

  typedef struct packed {
    logic [3:0]  ctl;
    logic [14:0] seg;
    logic [1:0]  idx;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          k = 0;
  logic [14:0] pat [4];

  task automatic set_pat(input logic [14:0] p0, p1, p2, p3);
    pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
  endtask

  // k = enabled cycles since the last reset or en-low edge; slot of 4 cycles, 1 dead.
  task automatic step();
    exp_t e;
    int s, d, ph;
    if (!rst_n || !en) begin
      e.ctl = 4'hF; e.seg = FTSD_BLANK; e.idx = 2'd0;
      k = 0;
    end else begin
      s  = k % 4;
      d  = (k / 4) % 4;
      ph = (k / 32) % 2;
      if (s == 0) begin
        e.ctl = 4'hF; e.seg = FTSD_BLANK;
      end else begin
        e.ctl = ~(4'b0001 << d);
        e.seg = (blink[d] && ph == 1) ? FTSD_BLANK : pat[d];
      end
      e.idx = 2'(((k + 1) / 4) % 4);
      k++;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (ftsd_ctl !== e.ctl || ftsd !== e.seg || scan_idx !== e.idx) begin
          miscompares++;
          $display("FAIL scan t=%0t: got ctl=%b ftsd=%h idx=%0d, expected ctl=%b ftsd=%h idx=%0d",
                   $time, ftsd_ctl, ftsd, scan_idx, e.ctl, e.seg, e.idx);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!$isunknown(ftsd_ctl) && $countones(~ftsd_ctl) > 1) begin
      miscompares++;
      $display("FAIL onehot t=%0t: ftsd_ctl=%b has more than one low bit", $time, ftsd_ctl);
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; lzs = 1'b0;
    digits = 16'h1234; blank = 4'h0; blink = 4'h0;
    set_pat(FTSD_FOUR, FTSD_THREE, FTSD_TWO, FTSD_ONE);
    @(negedge clk);
    run(2);

    rst_n = 1'b1; en = 1'b1;
    run(32);

    digits = 16'h0070; lzs = 1'b1;
    set_pat(FTSD_ZERO, FTSD_SEVEN, FTSD_BLANK, FTSD_BLANK);
    run(16);
    digits = 16'h0000;
    set_pat(FTSD_ZERO, FTSD_BLANK, FTSD_BLANK, FTSD_BLANK);
    run(16);

    lzs = 1'b0; digits = 16'h9E5F;
    set_pat(FTSD_F, FTSD_FIVE, FTSD_E, FTSD_NINE);
    run(16);

    digits = 16'hABCD; blink = 4'b0001;
    set_pat(FTSD_D, FTSD_C, FTSD_B, FTSD_A);
    run(96);
    blank = 4'b0010;
    set_pat(FTSD_D, FTSD_BLANK, FTSD_B, FTSD_A);
    run(16);
    blank = 4'h0; blink = 4'h0;

    digits = 16'h1234;
    set_pat(FTSD_FOUR, FTSD_THREE, FTSD_TWO, FTSD_ONE);
    en = 1'b0; step(); en = 1'b1;
    repeat (16) if (k % 16 != 10) step();
    en = 1'b0; step(); en = 1'b1;
    run(24);

    repeat (16) if (k % 16 != 14) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    run(24);

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries never compared, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
